// File: rtl/dual_port_mem_ctrl.sv
// dual_port_mem_ctrl: one RAM shared by a fetch port and a load/store port.
// Define MEM_WPROT_EN to block stores below PROT_LIMIT and flag them on err.
module dual_port_mem_ctrl #(
  parameter int WIDTH       = 32,
  parameter int ADDRSIZE    = 12,
  parameter int WAIT_STATES = 1,
  parameter int PROT_LIMIT  = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [ADDRSIZE-1:0] i_addr,
  output logic [WIDTH-1:0]    i_rdata,
  output logic                i_ack,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDRSIZE-1:0] d_addr,
  input  logic [WIDTH-1:0]    d_wdata,
  output logic [WIDTH-1:0]    d_rdata,
  output logic                d_ack,
  output logic                busy,
  output logic                err
);
  localparam int MEMSIZE = 1 << ADDRSIZE;
`ifdef MEM_WPROT_EN
  localparam bit WPROT = 1'b1;
`else
  localparam bit WPROT = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic                last_d_q;
  logic                gnt_d_q;
  logic [ADDRSIZE-1:0] addr_q;
  logic                we_q;
  logic [WIDTH-1:0]    wdata_q;
  logic                i_ack_q, d_ack_q, err_q;
  logic [WIDTH-1:0]    i_rdata_q, d_rdata_q;
  logic [WIDTH-1:0]    mem_q [MEMSIZE];

  logic                idle, pick_d, grant;
  logic                cur_d, cur_we, prot, enter_resp;
  logic [ADDRSIZE-1:0] cur_addr;
  logic [WIDTH-1:0]    cur_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_d_q  <= 1'b0;
      gnt_d_q   <= 1'b0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      err_q     <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      i_ack_q <= (state_q == RESP) && !gnt_d_q;
      d_ack_q <= (state_q == RESP) && gnt_d_q;
      err_q   <= (state_q == RESP) && prot;
      if (grant) begin
        gnt_d_q  <= pick_d;
        last_d_q <= pick_d;
        addr_q   <= cur_addr;
        we_q     <= cur_we;
        wdata_q  <= d_wdata;
      end
      if (enter_resp && !cur_we) begin
        if (cur_d) d_rdata_q <= mem_q[cur_addr];
        else       i_rdata_q <= mem_q[cur_addr];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (enter_resp && cur_we && !prot)
      mem_q[cur_addr] <= cur_wdata;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          if (WAIT_STATES == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = 3'(WAIT_STATES);
          end
        end
      end
      WAIT: begin
        if (cnt_q <= 3'd1) state_d = RESP;
        else               cnt_d   = cnt_q - 3'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // In IDLE the access is taken straight from the ports so that a
  // zero-wait grant can read/write on the same edge it is granted.
  always_comb begin
    idle       = (state_q == IDLE);
    pick_d     = d_req && (!i_req || !last_d_q);
    grant      = idle && (i_req || d_req);
    cur_d      = idle ? pick_d : gnt_d_q;
    cur_addr   = idle ? (pick_d ? d_addr : i_addr) : addr_q;
    cur_we     = idle ? (pick_d && d_we) : we_q;
    cur_wdata  = idle ? d_wdata : wdata_q;
    prot       = WPROT && cur_we && (int'(cur_addr) < PROT_LIMIT);
    enter_resp = !rst && (state_d == RESP) && (state_q != RESP);
    busy       = !idle;
  end

  assign i_ack   = i_ack_q;
  assign d_ack   = d_ack_q;
  assign err     = err_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
endmodule

// File: tb/tb_dual_port_mem_ctrl.sv
// tb_dual_port_mem_ctrl: four controllers with WAIT_STATES 0..3, directed
// plus random req/ack traffic checked against an array/latency model.
module tb_dual_port_mem_ctrl;
`ifdef MEM_WPROT_EN
  localparam bit PROT_ON = 1'b1;
`else
  localparam bit PROT_ON = 1'b0;
`endif
  localparam logic [11:0] FA = PROT_ON ? 12'd256 : 12'd0;

  logic        clk = 1'b0;
  logic        rst     [4];
  logic        i_req   [4];
  logic [11:0] i_addr  [4];
  logic [31:0] i_rdata [4];
  logic        i_ack   [4];
  logic        d_req   [4];
  logic        d_we    [4];
  logic [11:0] d_addr  [4];
  logic [31:0] d_wdata [4];
  logic [31:0] d_rdata [4];
  logic        d_ack   [4];
  logic        busy    [4];
  logic        err     [4];

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] mref [int];
  logic [31:0] ir_m [4];
  logic [31:0] dr_m [4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    dual_port_mem_ctrl #(.WAIT_STATES(g)) u_dut (
      .clk    (clk),
      .rst    (rst[g]),
      .i_req  (i_req[g]),
      .i_addr (i_addr[g]),
      .i_rdata(i_rdata[g]),
      .i_ack  (i_ack[g]),
      .d_req  (d_req[g]),
      .d_we   (d_we[g]),
      .d_addr (d_addr[g]),
      .d_wdata(d_wdata[g]),
      .d_rdata(d_rdata[g]),
      .d_ack  (d_ack[g]),
      .busy   (busy[g]),
      .err    (err[g])
    );
  end

  task automatic check(input string tag, input int w,
                       input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s w%0d: observed %0h expected %0h", tag, w, obs, exp);
    end
  endtask

  task automatic check_rdata(input int w);
    check("i_rdata", w, i_rdata[w], ir_m[w]);
    check("d_rdata", w, d_rdata[w], dr_m[w]);
  endtask

  task automatic rst_dut(input int w);
    @(negedge clk);
    rst[w] = 1'b1;
    repeat (2) @(negedge clk);
    rst[w] = 1'b0;
    ir_m[w] = '0;
    dr_m[w] = '0;
  endtask

  task automatic access(input int w, input bit pd, input bit we,
                        input logic [11:0] a, input logic [31:0] wd);
    int lat;
    bit got;
    bit pr;
    int key;
    key = w * 4096 + int'(a);
    pr  = PROT_ON && pd && we && (a < 12'd256);
    @(negedge clk);
    if (pd) begin
      d_req[w] = 1'b1; d_we[w] = we; d_addr[w] = a; d_wdata[w] = wd;
    end else begin
      i_req[w] = 1'b1; i_addr[w] = a;
    end
    lat = 0;
    got = 1'b0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      got = i_ack[w] | d_ack[w];
    end
    i_req[w] = 1'b0;
    d_req[w] = 1'b0;
    check("latency", w, 32'(lat), 32'(w + 2));
    check("ack_port", w, 32'(d_ack[w]), 32'(pd));
    check("err", w, 32'(err[w]), 32'(pr));
    check("busy_in_ack", w, 32'(busy[w]), 32'd0);
    if (pd && we) begin
      if (!pr) mref[key] = wd;
    end else begin
      // Never-written words have no defined content; take them as found.
      if (!mref.exists(key)) mref[key] = pd ? d_rdata[w] : i_rdata[w];
      if (pd) dr_m[w] = mref[key];
      else    ir_m[w] = mref[key];
    end
    check_rdata(w);
    @(negedge clk);
    check("ack_pulse", w, 32'({i_ack[w], d_ack[w]}), 32'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, cyc, last;
    for (int w = 0; w < 4; w++) begin
      rst[w] = 1'b1; i_req[w] = 1'b0; i_addr[w] = '0;
      d_req[w] = 1'b0; d_we[w] = 1'b0; d_addr[w] = '0; d_wdata[w] = '0;
      ir_m[w] = '0; dr_m[w] = '0;
    end
    repeat (3) @(negedge clk);
    for (int w = 0; w < 4; w++) rst[w] = 1'b0;
    repeat (5) @(negedge clk);
    for (int w = 0; w < 4; w++) begin
      check("rst_i_ack", w, 32'(i_ack[w]), 32'd0);
      check("rst_d_ack", w, 32'(d_ack[w]), 32'd0);
      check("rst_busy", w, 32'(busy[w]), 32'd0);
      check("rst_err", w, 32'(err[w]), 32'd0);
      check_rdata(w);
    end

    access(1, 1'b1, 1'b1, 12'd10, 32'h0000_00AB);
    access(1, 1'b1, 1'b0, 12'd10, 32'h0);
    check("load10", 1, d_rdata[1], 32'h0000_00AB);

    for (int w = 0; w < 4; w += 3) begin
      access(w, 1'b1, 1'b1, FA, 32'h1234_5678);
      access(w, 1'b0, 1'b0, FA, 32'h0);
      check("fetch", w, i_rdata[w], 32'h1234_5678);
    end

    // Both ports held: grants must alternate D,I,D,I from reset.
    access(1, 1'b1, 1'b1, 12'd40, 32'h4040_4040);
    access(1, 1'b1, 1'b1, 12'd41, 32'h4141_4141);
    rst_dut(1);
    @(negedge clk);
    i_req[1] = 1'b1; i_addr[1] = 12'd41;
    d_req[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 12'd40;
    n = 0; cyc = 0; last = 0;
    while (n < 4 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (i_ack[1] | d_ack[1]) begin
        n++;
        check("arb_port", 1, 32'(d_ack[1]), 32'(n % 2));
        check("arb_gap", 1, 32'(cyc - last), 32'd3);
        check("arb_busy", 1, 32'(busy[1]), 32'd0);
        last = cyc;
        if (d_ack[1]) dr_m[1] = mref[4096 + 40];
        else          ir_m[1] = mref[4096 + 41];
        check_rdata(1);
        if (n == 4) begin
          i_req[1] = 1'b0;
          d_req[1] = 1'b0;
        end
      end
    end
    i_req[1] = 1'b0;
    d_req[1] = 1'b0;
    check("arb_count", 1, 32'(n), 32'd4);
    @(negedge clk);
    check("arb_end", 1, 32'({i_ack[1], d_ack[1]}), 32'd0);

    // Reset lands in the WAIT cycle of a store: nothing may complete.
    access(2, 1'b1, 1'b1, 12'd20, 32'h0000_0055);
    @(negedge clk);
    d_req[2] = 1'b1; d_we[2] = 1'b1; d_addr[2] = 12'd20;
    d_wdata[2] = 32'hDEAD_BEEF;
    @(negedge clk);
    check("wait_busy", 2, 32'(busy[2]), 32'd1);
    rst[2] = 1'b1;
    d_req[2] = 1'b0;
    @(negedge clk);
    rst[2] = 1'b0;
    ir_m[2] = '0;
    dr_m[2] = '0;
    check("abort_busy", 2, 32'(busy[2]), 32'd0);
    check("abort_ack", 2, 32'(d_ack[2]), 32'd0);
    check_rdata(2);
    repeat (4) begin
      @(negedge clk);
      check("abort_noack", 2, 32'(d_ack[2]), 32'd0);
    end
    access(2, 1'b1, 1'b0, 12'd20, 32'h0);
    check("abort_mem", 2, d_rdata[2], 32'h0000_0055);

    access(1, 1'b1, 1'b0, 12'd5, 32'h0);
    access(1, 1'b1, 1'b1, 12'd5, 32'hFFFF_FFFF);
    access(1, 1'b1, 1'b0, 12'd5, 32'h0);
    access(1, 1'b1, 1'b1, 12'd300, 32'h0000_0300);
    access(1, 1'b1, 1'b0, 12'd300, 32'h0);
    check("store300", 1, d_rdata[1], 32'h0000_0300);

    for (int w = 0; w < 4; w++) begin
      for (int k = 0; k < 25; k++) begin
        bit pd, we;
        logic [11:0] a;
        a  = 12'($urandom_range(0, 15) + (($urandom % 2) ? 256 : 0));
        pd = 1'($urandom % 2);
        we = pd && 1'($urandom % 2);
        if (!mref.exists(w * 4096 + int'(a))) begin
          pd = 1'b1;
          we = 1'b1;
        end
        access(w, pd, we, a, $urandom);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dual_port_mem_ctrl.md
Name: dual_port_mem_ctrl

Overview:
- Synthesizable, parametrised successor to the bench-side behavioural memories.
- One storage array shared by an instruction-fetch port and a data load/store port.
- Each port uses a req/ack handshake with configurable wait states, so CPU cores are exercised against non-zero memory latency.
- Sits between `instruction_set_model` (or its successors) and the on-chip RAM. Arbitrates between the two ports and serialises their accesses.

Parameters:
- WIDTH, 32: data word width in bits.
- ADDRSIZE, 12: word address width; array depth MEMSIZE = 1<<ADDRSIZE.
- WAIT_STATES, 1: extra cycles per access; legal range 0..7.
- PROT_LIMIT, 256: word addresses below this value are protected; used only with MEM_WPROT_EN.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- i_req  in  1  instruction fetch request; held high until i_ack.
- i_addr  in  ADDRSIZE  fetch word address; stable while i_req high.
- i_rdata  out  WIDTH  fetched word; valid in the i_ack cycle.
- i_ack  out  1  one-cycle fetch completion pulse.
- d_req  in  1  data access request; held high until d_ack.
- d_we  in  1  1 = store, 0 = load; stable while d_req high.
- d_addr  in  ADDRSIZE  data word address.
- d_wdata  in  WIDTH  store data.
- d_rdata  out  WIDTH  load data; valid in the d_ack cycle.
- d_ack  out  1  one-cycle data completion pulse (loads and stores).
- busy  out  1  high while an access is in progress (state not IDLE).
- err  out  1  protection violation pulse, coincident with d_ack.

Behaviour:
- Reset: synchronous, active-high.
  - State goes to IDLE. i_ack, d_ack, busy and err go to 0. i_rdata and d_rdata go to 0. The wait counter and the last-grant flag are cleared.
  - Array contents are not cleared.
- State machine: IDLE -> WAIT (when WAIT_STATES>0) -> RESP -> IDLE.
  - With WAIT_STATES=0 the path is IDLE -> RESP.
  - WAIT counts down from WAIT_STATES to 1.
- Latency: a request sampled in IDLE at edge k gets its ack asserted after edge k+1+WAIT_STATES, for exactly one cycle.
- Throughput: at most one access every 2+WAIT_STATES cycles.
- Grant happens only in IDLE. The granted port, address, we and wdata are latched at the grant edge.
  - Input changes after the grant are ignored until the ack.
- Arbitration:
  - Only one port requesting: that port is granted.
  - Both ports requesting: the port not granted last time wins. After reset, data wins.
  - Neither port can be starved.
- Loads and fetches: the rdata register of the granted port loads array[addr] at the edge entering RESP.
  - The rdata register holds its value until that port's next completed read. The other port's rdata is untouched.
- Stores: the array is written at the edge entering RESP. d_rdata is unchanged.
  - A load or fetch of the same address granted afterwards returns the new data.
- Request dropped before ack (protocol violation): the access still completes and ack still pulses; the requester ignores it.
- req still high in the ack cycle: treated as a new request at the following IDLE edge. A requester wanting a single access drops req in its ack cycle.
- Address: ADDRSIZE bits index the array directly; there is no out-of-range case.
- Reset during WAIT or RESP: the access is aborted, no ack is issued, and no array write takes place if reset is sampled on or before the write edge.
- busy = (state != IDLE).

Optional Feature:
- MEM_WPROT_EN defined:
  - A store with d_addr < PROT_LIMIT completes normally with d_ack after the usual latency.
  - The array is not written.
  - err pulses high in the same cycle as d_ack.
  - Loads and fetches of protected addresses are unaffected.
- MEM_WPROT_EN undefined:
  - err is tied to 0.
  - All stores write; PROT_LIMIT is unused.

Test Plan:
- Reset, then idle 5 cycles -> i_ack=d_ack=busy=err=0, i_rdata=d_rdata=0.
- WAIT_STATES=1: store d_addr=10, d_wdata=0x0000_00AB at edge k -> d_ack after edge k+2. Then load 10 -> d_rdata=0xAB in its d_ack cycle.
- WAIT_STATES=0 and 3: fetch i_addr=0 preloaded 0x1234_5678 -> i_ack at k+1 and k+4 respectively, with i_rdata=0x12345678.
- i_req and d_req held high together for 4 grants -> grant order D,I,D,I. Each ack is one cycle; busy drops for one IDLE cycle between accesses.
- rst asserted in the WAIT cycle of a store to addr 20 (WAIT_STATES=2) -> no d_ack, array[20] unchanged, busy=0 on the next cycle.
- MEM_WPROT_EN, PROT_LIMIT=256: store 0xFFFF_FFFF to addr 5 -> d_ack with err=1, array[5] unchanged. Store to addr 300 -> err=0 and the write lands.
